// File: rtl/lstm_output_dense.sv
// Dense output layer behind the LSTM stage: y[o] = by[o] + sum_j Wy[o][j]*h[j],
// computed with one time-multiplexed MAC and saturated back to Q(QN).(QM).
module lstm_output_dense #(
    parameter int HIDDEN_SZ      = 8,
    parameter int OUTPUT_SZ      = 1,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int WADDR_BITWIDTH = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [HIDDEN_SZ*(QN+QM+1)-1:0]    hiddenVec,
    input  logic                              hiddenValid,
    input  logic                              wEn,
    input  logic [WADDR_BITWIDTH-1:0]         wAddr,
    input  logic [QN+QM:0]                    wData,
    output logic [OUTPUT_SZ*(QN+QM+1)-1:0]    outVec,
    output logic                              outReady,
    output logic                              busy,
    output logic                              overrun
);

    localparam int BW    = QN + QM + 1;
    localparam int ACC_W = 2 * BW + 4;
    localparam int AW    = WADDR_BITWIDTH;
    localparam int NW    = OUTPUT_SZ * (HIDDEN_SZ + 1);
    localparam int JW    = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1;
    localparam int OW    = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BIAS, S_MAC, S_STORE} state_t;

    state_t                   r_state;
    logic [OW-1:0]            r_o;
    logic [JW-1:0]            r_j;
    logic [AW-1:0]            r_ptr;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [BW-1:0]     r_h    [HIDDEN_SZ];
    logic signed [BW-1:0]     r_wmem [2**AW];
    logic [OUTPUT_SZ*BW-1:0]  r_out;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_overrun;

    logic signed [BW-1:0]     w_bias;
    logic signed [BW-1:0]     w_wt;
    logic signed [BW-1:0]     w_h;
    logic signed [2*BW-1:0]   w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_shift;
    logic [BW-1:0]            w_sat;
    logic                     w_wr_ok;

    // r_ptr holds the base address o*(HIDDEN_SZ+1) of the current neuron's row.
    assign w_bias     = r_wmem[r_ptr + AW'(HIDDEN_SZ)];
    assign w_wt       = r_wmem[r_ptr + AW'(r_j)];
    assign w_h        = r_h[r_j];
    assign w_prod     = w_h * w_wt;
    assign w_prod_ext = {{(ACC_W-2*BW){w_prod[2*BW-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-BW-QM){w_bias[BW-1]}}, w_bias, {QM{1'b0}}};
    assign w_shift    = r_acc >>> QM;

    // Fits in BW bits only if every bit above the result sign matches it.
    always_comb begin
        w_sat = w_shift[BW-1:0];
        if (!((&w_shift[ACC_W-1:BW-1]) || !(|w_shift[ACC_W-1:BW-1])))
            w_sat = w_shift[ACC_W-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
    end

    assign w_wr_ok = wEn && (r_state == S_IDLE) && (int'(wAddr) < NW);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_o       <= '0;
            r_j       <= '0;
            r_ptr     <= '0;
            r_acc     <= '0;
            for (int unsigned k = 0; k < HIDDEN_SZ; k++) r_h[k] <= '0;
            for (int unsigned k = 0; k < 2**AW; k++) r_wmem[k] <= '0;
            r_out     <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (w_wr_ok) r_wmem[wAddr] <= wData;
            if (hiddenValid && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (hiddenValid) begin
                        for (int unsigned k = 0; k < HIDDEN_SZ; k++)
                            r_h[k] <= hiddenVec[k*BW +: BW];
                        r_o     <= '0;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    r_acc   <= w_bias_ext;
                    r_j     <= '0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_j   <= r_j + 1'b1;
                    if (r_j == JW'(HIDDEN_SZ-1)) r_state <= S_STORE;
                end
                S_STORE: begin
                    for (int unsigned k = 0; k < OUTPUT_SZ; k++)
                        if (r_o == OW'(k)) r_out[k*BW +: BW] <= w_sat;
                    if (r_o == OW'(OUTPUT_SZ-1)) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_o     <= r_o + 1'b1;
                        r_ptr   <= r_ptr + AW'(HIDDEN_SZ+1);
                        r_state <= S_BIAS;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign outVec   = r_out;
    assign outReady = r_ready;
    assign busy     = r_busy;
    assign overrun  = r_overrun;

endmodule
